// File: rtl/tof_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tof_pkg
//  Description : Shared types and helpers for the ToF radius frame path.
//                The address packing is shared with the read FSM so both
//                sides agree on the BRAM layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package tof_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ZONES = ROWS * COLS;

  // Frame writer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2,
    REARM = 2'd3
  } state_e;

  // BRAM layout: {row[2:0], sensor_id[2:0], col[2:0]}
  function automatic logic [8:0] pack_addr(input logic [5:0] idx,
                                           input logic [2:0] sensor_id);
    return {idx[5:3], sensor_id, idx[2:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tof_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tof_frame_writer
//  Description : Accepts the 8x8 zone radius stream, sanitises each sample,
//                writes the frame into the shared radius BRAM and raises drdy
//                until the reader releases the frame. Counts completed frames
//                and stream errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tof_frame_writer
  import tof_pkg::*;
#(
  parameter int              DATA_W      = 16,
  parameter int              ROWS        = 8,
  parameter int              COLS        = 8,
  parameter int              ADDR_W      = 9,
  parameter logic [DATA_W-1:0] MAX_RADIUS  = 16'd4000,
  parameter logic [DATA_W-1:0] INVALID_VAL = 16'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_invalid,
  input  logic [2:0]        sensor_id,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic              rd_done,
  output logic              drdy,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt
);

  // Index of the final zone of a frame
  localparam logic [5:0] c_last_idx = 6'(ROWS * COLS - 1);

  state_e              r_state;
  logic [5:0]          r_idx;
  logic [2:0]          r_sensor_id;
  logic                r_s_ready;
  logic                r_bram_we;
  logic [ADDR_W-1:0]   r_bram_addr;
  logic [DATA_W-1:0]   r_bram_din;
  logic                r_drdy;
  logic [15:0]         r_frame_cnt;
  logic [7:0]          r_err_cnt;

  logic                w_accept;
  logic [DATA_W-1:0]   w_din;
  logic [5:0]          w_wr_idx;
  logic [2:0]          w_wr_sid;
  logic [ADDR_W-1:0]   w_wr_addr;

  assign w_accept  = s_valid & r_s_ready;
  // An SOF sample always lands in zone 0 under the freshly presented sensor id
  assign w_wr_idx  = s_sof ? 6'd0 : r_idx;
  assign w_wr_sid  = s_sof ? sensor_id : r_sensor_id;
  assign w_wr_addr = ADDR_W'(pack_addr(w_wr_idx, w_wr_sid));

  // Sample sanitising: invalid flag wins over saturation
  always_comb begin
    w_din = s_data;
    if (s_invalid) begin
      w_din = INVALID_VAL;
    end else if (s_data > MAX_RADIUS) begin
      w_din = MAX_RADIUS;
    end
  end

  // Frame control FSM with registered handshake, write port and status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_idx       <= 6'd0;
      r_sensor_id <= 3'd0;
      r_s_ready   <= 1'b0;
      r_bram_we   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
      r_drdy      <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_bram_we <= 1'b0;
      case (r_state)
        IDLE: begin
          r_s_ready <= 1'b1;
          r_drdy    <= 1'b0;
          if (w_accept) begin
            if (s_sof) begin
              r_bram_we   <= 1'b1;
              r_bram_addr <= w_wr_addr;
              r_bram_din  <= w_din;
              r_sensor_id <= sensor_id;
              r_idx       <= 6'd1;
              r_state     <= WRITE;
            end else if (r_err_cnt != 8'hFF) begin
              // Sample outside a frame is dropped
              r_err_cnt <= r_err_cnt + 8'd1;
            end
          end
        end
        WRITE: begin
          if (w_accept) begin
            r_bram_we   <= 1'b1;
            r_bram_addr <= w_wr_addr;
            r_bram_din  <= w_din;
            if (s_sof) begin
              // Unexpected SOF restarts the frame at zone 0
              r_sensor_id <= sensor_id;
              r_idx       <= 6'd1;
              if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
              end
            end else if (r_idx == c_last_idx) begin
              r_idx       <= 6'd0;
              r_s_ready   <= 1'b0;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_state     <= FULL;
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
        end
        FULL: begin
          // drdy follows one cycle after entry so the last write lands first
          r_s_ready <= 1'b0;
          if (rd_done) begin
            r_drdy  <= 1'b0;
            r_state <= REARM;
          end else begin
            r_drdy <= 1'b1;
          end
        end
        REARM: begin
          r_drdy    <= 1'b0;
          r_s_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign bram_we   = r_bram_we;
  assign bram_addr = r_bram_addr;
  assign bram_din  = r_bram_din;
  assign drdy      = r_drdy;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tof_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tof_frame_writer
//  Description : Self-checking bench for tof_frame_writer. A frame-level
//                reference model predicts BRAM writes, counters and drdy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tof_frame_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        s_invalid = 1'b0;
  logic        rd_done = 1'b0;
  logic [15:0] s_data = 16'd0;
  logic [2:0]  sensor_id = 3'd0;
  logic        s_ready;
  logic        bram_we;
  logic        drdy;
  logic [8:0]  bram_addr;
  logic [15:0] bram_din;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  tof_frame_writer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .s_invalid (s_invalid),
    .sensor_id (sensor_id),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .rd_done   (rd_done),
    .drdy      (drdy),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Observed and predicted BRAM writes
  int got_addr[$];
  int got_din[$];
  int exp_addr[$];
  int exp_din[$];

  // Reference model state
  bit m_open  = 1'b0;
  int m_zone  = 0;
  int m_sid   = 0;
  int m_err   = 0;
  int m_frames = 0;

  typedef struct {
    int zone;
    int data;
    bit inv;
    int exp;
  } vec_t;
  vec_t tbl[7];

  always @(negedge clk) begin
    if (rst && bram_we) begin
      got_addr.push_back(int'(bram_addr));
      got_din.push_back(int'(bram_din));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sanitize(input int d, input bit inv);
    if (inv) return 0;
    if (d > 4000) return 4000;
    return d;
  endfunction

  // Frame-level behaviour: what an accepted sample does to BRAM and counters
  task automatic model_sample(input int d, input bit sof, input bit inv, input int sid);
    if (!m_open && !sof) begin
      if (m_err < 255) m_err++;
      return;
    end
    if (sof) begin
      if (m_open && m_err < 255) m_err++;
      m_open = 1'b1;
      m_zone = 0;
      m_sid  = sid;
    end
    exp_addr.push_back((m_zone / 8) * 64 + m_sid * 8 + (m_zone % 8));
    exp_din.push_back(sanitize(d, inv));
    m_zone++;
    if (m_zone == 64) begin
      m_open   = 1'b0;
      m_frames = (m_frames + 1) % 65536;
    end
  endtask

  task automatic model_reset();
    m_open = 1'b0; m_zone = 0; m_sid = 0; m_err = 0; m_frames = 0;
    got_addr.delete(); got_din.delete(); exp_addr.delete(); exp_din.delete();
  endtask

  // Offer one sample and hold it until the DUT takes it (bounded)
  task automatic send(input int d, input bit sof, input bit inv, input int sid);
    int waited;
    waited = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = 16'(d); s_sof = sof; s_invalid = inv; sensor_id = 3'(sid);
    while (!s_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      check("send_timeout_ready", int'(s_ready), 1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_sample(d, sof, inv, sid);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_valid = 1'b0; s_sof = 1'b0; s_invalid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Called right after the zone-63 handshake
  task automatic frame_end();
    idle(1);
    check("last_we", int'(bram_we), 1);
    check("drdy_early", int'(drdy), 0);
    check("ready_in_full", int'(s_ready), 0);
    check("frame_cnt", int'(frame_cnt), m_frames);
    @(negedge clk);
    check("drdy_rise", int'(drdy), 1);
    check("we_after_frame", int'(bram_we), 0);
    check("err_cnt", int'(err_cnt), m_err);
  endtask

  task automatic compare_writes(input string name);
    int n;
    check({name, "_count"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr[%0d]", name, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_din[%0d]", name, i), got_din[i], exp_din[i]);
    end
    got_addr.delete(); got_din.delete(); exp_addr.delete(); exp_din.delete();
  endtask

  task automatic release_frame();
    @(negedge clk); rd_done = 1'b1;
    @(negedge clk); rd_done = 1'b0;
    check("rearm_drdy", int'(drdy), 0);
    check("rearm_ready", int'(s_ready), 0);
    @(negedge clk);
    check("idle_ready", int'(s_ready), 1);
    check("idle_drdy", int'(drdy), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_s_ready"}, int'(s_ready), 0);
    check({name, "_bram_we"}, int'(bram_we), 0);
    check({name, "_bram_addr"}, int'(bram_addr), 0);
    check({name, "_bram_din"}, int'(bram_din), 0);
    check({name, "_drdy"}, int'(drdy), 0);
    check({name, "_frame_cnt"}, int'(frame_cnt), 0);
    check({name, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bit inv;
    int sid;

    tbl[0] = '{zone: 5, data: 5000,  inv: 1'b0, exp: 4000};
    tbl[1] = '{zone: 9, data: 123,   inv: 1'b1, exp: 0};
    tbl[2] = '{zone: 0, data: 4000,  inv: 1'b0, exp: 4000};
    tbl[3] = '{zone: 1, data: 4001,  inv: 1'b0, exp: 4000};
    tbl[4] = '{zone: 2, data: 65535, inv: 1'b0, exp: 4000};
    tbl[5] = '{zone: 3, data: 3999,  inv: 1'b0, exp: 3999};
    tbl[6] = '{zone: 4, data: 5000,  inv: 1'b1, exp: 0};

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Nominal frame, back-to-back, radii 151..158 per row
    for (int z = 0; z < 64; z++) send(151 + (z % 8), z == 0, 1'b0, 0);
    frame_end();
    check("nominal_frame_cnt", int'(frame_cnt), 1);
    compare_writes("nominal");

    // Samples offered while FULL must be ignored
    @(negedge clk);
    s_valid = 1'b1; s_sof = 1'b1; s_data = 16'd77;
    repeat (5) begin
      @(negedge clk);
      check("full_ready", int'(s_ready), 0);
    end
    idle(1);
    check("full_no_write", got_addr.size(), 0);
    check("full_drdy_held", int'(drdy), 1);
    repeat (10) @(negedge clk);
    release_frame();

    // Sanitising frame driven from the vector table
    for (int z = 0; z < 64; z++) begin
      d = 1000 + z;
      inv = 1'b0;
      for (int k = 0; k < 7; k++) begin
        if (tbl[k].zone == z) begin
          d = tbl[k].data;
          inv = tbl[k].inv;
        end
      end
      send(d, z == 0, inv, 5);
    end
    frame_end();
    check("second_frame_cnt", int'(frame_cnt), 2);
    for (int k = 0; k < 7; k++) begin
      if (got_din.size() > tbl[k].zone) begin
        check($sformatf("tbl_din_zone%0d", tbl[k].zone), got_din[tbl[k].zone], tbl[k].exp);
        check($sformatf("tbl_addr_zone%0d", tbl[k].zone), got_addr[tbl[k].zone],
              (tbl[k].zone / 8) * 64 + 40 + (tbl[k].zone % 8));
      end else begin
        check("tbl_missing_write", got_din.size(), tbl[k].zone + 1);
      end
    end
    compare_writes("sanitise");
    repeat (20) @(negedge clk);
    release_frame();

    // Stream errors: orphan samples, then SOF restart mid-frame
    for (int i = 0; i < 3; i++) send(10 + i, 1'b0, 1'b0, 2);
    idle(3);
    check("orphan_err_cnt", int'(err_cnt), 3);
    check("orphan_no_write", got_addr.size(), 0);
    for (int z = 0; z < 30; z++) send(200 + z, z == 0, 1'b0, 2);
    send(500, 1'b1, 1'b0, 6);
    idle(2);
    check("restart_err_cnt", int'(err_cnt), 4);
    for (int z = 1; z < 63; z++) send(500 + z, 1'b0, 1'b0, 6);
    idle(2);
    check("restart_no_drdy", int'(drdy), 0);
    send(563, 1'b0, 1'b0, 6);
    frame_end();
    compare_writes("restart");
    repeat (20) @(negedge clk);
    release_frame();

    // Randomised frames with idle gaps
    for (int f = 0; f < 3; f++) begin
      sid = $urandom_range(0, 7);
      for (int z = 0; z < 64; z++) begin
        d = $urandom_range(0, 8000);
        inv = ($urandom_range(0, 9) == 0);
        send(d, z == 0, inv, sid);
        if (z != 63 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      frame_end();
      compare_writes("random");
      repeat ($urandom_range(1, 25)) @(negedge clk);
      release_frame();
    end

    // Asynchronous reset in the middle of a frame
    for (int z = 0; z < 40; z++) send(300 + z, z == 0, 1'b0, 1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    idle(2);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) send(40 + i, 1'b0, 1'b0, 1);
    idle(3);
    check("post_reset_err", int'(err_cnt), 3);
    check("post_reset_no_write", got_addr.size(), 0);
    check("post_reset_drdy", int'(drdy), 0);
    for (int z = 0; z < 64; z++) send(700 + z, z == 0, 1'b0, 3);
    frame_end();
    check("post_reset_frame_cnt", int'(frame_cnt), 1);
    compare_writes("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tof_frame_writer.md
Name: tof_frame_writer

Overview:
- Upstream stage of the ToF readout chain. Receives the 8x8 zone radius stream from the sensor interface as a valid/ready sample stream with start-of-frame marking.
- Writes each frame into the shared radius BRAM, then raises drdy to the sensor-data read FSM. Holds drdy until the reader signals completion, then re-arms for the next frame.
- Also sanitises samples: flags invalid zones, saturates oversize radii, and counts frames and stream errors.

Parameters:
- DATA_W, 16, radius sample width.
- ROWS, 8, zone rows per frame.
- COLS, 8, zone columns per frame.
- ADDR_W, 9, BRAM address width.
- MAX_RADIUS, 16'd4000, saturation limit. Larger samples are written as MAX_RADIUS.
- INVALID_VAL, 16'd0, value written for samples flagged invalid.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous active-low reset.
- s_valid  input  1  sample valid.
- s_ready  output  1  block accepts a sample this cycle.
- s_data  input  DATA_W  raw radius.
- s_sof  input  1  sample is zone 0 of a frame.
- s_invalid  input  1  sensor status marks zone measurement invalid.
- sensor_id  input  3  written into address bits [5:3]. Sampled at SOF.
- bram_we  output  1  BRAM write enable.
- bram_addr  output  ADDR_W  write address {row[2:0], sensor_id[2:0], col[2:0]}.
- bram_din  output  DATA_W  write data.
- rd_done  input  1  one-cycle pulse from the read FSM: frame consumed.
- drdy  output  1  complete frame present in BRAM (level).
- frame_cnt  output  16  completed frames, wraps at 16'hFFFF -> 0.
- err_cnt  output  8  stream errors, saturates at 8'hFF.

Behaviour:
- Reset (rst=0, async) values:
  - Outputs: s_ready=0, bram_we=0, bram_addr=0, bram_din=0, drdy=0, frame_cnt=0, err_cnt=0.
  - Internal: state=IDLE, zone index=0.
  - Reset mid-frame discards the partial frame. No drdy follows.
- States IDLE, WRITE, FULL, REARM.
  - IDLE: s_ready=1.
    - Handshake with s_sof=1 writes zone 0, latches sensor_id, goes to WRITE, idx=1.
    - Handshake with s_sof=0: sample dropped, err_cnt+1.
  - WRITE: s_ready=1.
    - Each handshake writes zone idx, then idx+1.
    - Handshake with s_sof=1 mid-frame: restart. That sample becomes zone 0, err_cnt+1, sensor_id re-latched.
    - Zone 63 accepted: go to FULL.
  - FULL: s_ready=0, drdy=1 starting the cycle after the zone-63 write (write committed first).
    - frame_cnt increments on entry.
    - rd_done=1 goes to REARM.
  - REARM: drdy=0, s_ready=0 for exactly one cycle, guaranteeing a drdy low edge. Then go to IDLE.
- rd_done outside FULL is ignored.
- Zone ordering: raster, idx[5:3]=row, idx[2:0]=col, so bram_addr={idx[5:3], sensor_id_q, idx[2:0]}.
- Write pipeline is one register stage.
  - Sample accepted at cycle N gives bram_we=1 with addr/din at N+1.
  - bram_we=0 in all other cycles.
- Data rule, priority top down:
  - s_invalid=1 writes INVALID_VAL.
  - s_data>MAX_RADIUS writes MAX_RADIUS.
  - Otherwise writes s_data.
- s_valid=0 in WRITE: idx holds, no timeout.

Decomposition:
- Package tof_pkg holds:
  - ROWS, COLS, ZONES=64.
  - Enum typedef for the state (IDLE, WRITE, FULL, REARM).
  - Function pack_addr(idx, sensor_id) returning the 9-bit address, shared with the read FSM's unpacking.
- No sub-module. A single module of roughly 150-200 lines.

Test Plan:
- Nominal frame: rst low 2 cycles, then 64 back-to-back samples (SOF on first) with data = radii 151..158 pattern, sensor_id=0 -> 64 writes at addresses {r,3'b0,c}, drdy rises 1 cycle after write 63, frame_cnt=1, s_ready=0.
- Release handshake: rd_done pulse 20 cycles into FULL -> drdy low for exactly 1 cycle (REARM), then s_ready=1. A second frame completes with frame_cnt=2.
- Sanitising:
  - Zone 5 carries s_data=16'd5000 -> written 4000.
  - Zone 9 carries s_invalid=1, s_data=123 -> written 0.
  - All other zones unchanged.
- Stream errors:
  - 3 samples without SOF in IDLE -> no writes, err_cnt=3.
  - SOF at zone 30 -> restart at address 0, err_cnt=4, drdy only after 64 further samples.
- Backpressure and idle gaps:
  - Random s_valid gaps in WRITE -> write count 64, order preserved.
  - Samples offered in FULL -> not accepted, nothing written.
- Async reset mid-frame: rst=0 at zone 40 -> all outputs 0 immediately. After release, a frame not starting with SOF is rejected, and a full SOF frame completes normally.
